// File: rtl/host_link_master.sv
// Host-side initiator for the seed/result UART byte protocol.
// Pushes seeds to the far-end module bank and collects async results.
module host_link_master #(
  parameter int NUM_OF_TAPS    = 5,
  parameter int PAYLOAD_BYTES  = 4,
  parameter int RESULT_BYTES   = 4 + NUM_OF_TAPS,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                      clk,
  input  logic                      res,
  output logic                      drl,
  output logic [7:0]                din,
  input  logic                      load,
  input  logic                      take,
  input  logic [7:0]                dout,
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic [PAYLOAD_BYTES*8-1:0] job_data,
  output logic                      job_done,
  output logic                      job_ok,
  output logic                      rslt_valid,
  output logic                      rslt_fail,
  output logic                      rslt_err,
  output logic [RESULT_BYTES*8-1:0] rslt_data,
  output logic                      timeout
);
  localparam int IW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int CW = $clog2(RESULT_BYTES + 1);

  localparam logic [7:0] B_START = 8'hF0;
  localparam logic [7:0] B_ACK   = 8'hF1;
  localparam logic [7:0] B_FOUND = 8'hF3;
  localparam logic [7:0] B_CAN   = 8'hF4;
  localparam logic [7:0] B_FAIL  = 8'hFA;
  localparam logic [7:0] B_ERR   = 8'hEE;
  localparam logic [7:0] B_END   = 8'hFF;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_WAIT_CAN = 3'd2;
  localparam logic [2:0] S_PAY      = 3'd3;
  localparam logic [2:0] S_END      = 3'd4;
  localparam logic [2:0] S_WAIT_ACK = 3'd5;
  localparam logic [2:0] S_RACK     = 3'd6;
  localparam logic [2:0] S_RECV     = 3'd7;

  logic [2:0]                state;
  logic                      pending;
  logic [PAYLOAD_BYTES*8-1:0] job_q;
  logic [IW-1:0]             idx;
  logic [CW-1:0]             cnt;
  logic [RESULT_BYTES*8-1:0] res_buf;
  logic [31:0]               timer;
  logic                      waiting;
  logic                      tmo;
  logic                      seed_ff;
  logic                      accept;
  logic                      sig_rx;

  assign waiting   = (state == S_WAIT_CAN) || (state == S_WAIT_ACK)
                  || (state == S_RECV);
  assign tmo       = waiting && (timer == 32'(TIMEOUT_CYCLES));
  assign job_ready = !res && (state == S_IDLE) && !pending;
  assign accept    = job_valid && job_ready;
  assign sig_rx    = take && ((dout == B_FOUND) || (dout == B_FAIL));

  // FF inside a seed would be mistaken for END by the far end
  always_comb begin
    seed_ff = 1'b0;
    for (int k = 0; k < PAYLOAD_BYTES; k++)
      if (job_data[8*k +: 8] == B_END) seed_ff = 1'b1;
  end

  always_comb begin
    drl = 1'b1;
    din = 8'h00;
    case (state)
      S_START: din = B_START;
      S_PAY:
        for (int k = 0; k < PAYLOAD_BYTES; k++)
          if (idx == IW'(k)) din = job_q[8*k +: 8];
      S_END:   din = B_END;
      S_RACK:  din = B_ACK;
      default: drl = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res || !waiting || take) timer <= '0;
    else if (timer != '1) timer <= timer + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state      <= S_IDLE;
      pending    <= 1'b0;
      job_q      <= '0;
      idx        <= '0;
      cnt        <= '0;
      res_buf    <= '0;
      job_done   <= 1'b0;
      job_ok     <= 1'b0;
      rslt_valid <= 1'b0;
      rslt_fail  <= 1'b0;
      rslt_err   <= 1'b0;
      rslt_data  <= '0;
      timeout    <= 1'b0;
    end else begin
      job_done   <= 1'b0;
      job_ok     <= 1'b0;
      rslt_valid <= 1'b0;
      rslt_err   <= 1'b0;
      timeout    <= 1'b0;
      if (accept) begin
        job_q <= job_data;
        if (seed_ff) job_done <= 1'b1;
        else pending <= 1'b1;
      end
      case (state)
        S_IDLE:
          if (sig_rx) begin
            rslt_fail <= (dout == B_FAIL);
            state     <= S_RACK;
          end else if (pending) begin
            state <= S_START;
          end
        S_START:
          if (load) state <= S_WAIT_CAN;
        S_WAIT_CAN:
          if (take && dout == B_CAN) begin
            idx   <= '0;
            state <= S_PAY;
          end else if (sig_rx) begin
            rslt_fail <= (dout == B_FAIL);
            state     <= S_RACK;
          end else if (tmo) begin
            timeout <= 1'b1;
            state   <= S_IDLE;
          end
        S_PAY:
          if (load) begin
            if (idx == IW'(PAYLOAD_BYTES - 1)) state <= S_END;
            else idx <= idx + 1'b1;
          end
        S_END:
          if (load) state <= S_WAIT_ACK;
        S_WAIT_ACK:
          if (take && (dout == B_ACK || dout == B_ERR)) begin
            job_done <= 1'b1;
            job_ok   <= (dout == B_ACK);
            pending  <= 1'b0;
            state    <= S_IDLE;
          end else if (tmo) begin
            timeout  <= 1'b1;
            job_done <= 1'b1;
            pending  <= 1'b0;
            state    <= S_IDLE;
          end
        S_RACK:
          if (load) begin
            cnt   <= '0;
            state <= S_RECV;
          end
        S_RECV:
          if (take) begin
            if (cnt == CW'(RESULT_BYTES)) begin
              rslt_valid <= 1'b1;
              rslt_err   <= (dout != B_END);
              rslt_data  <= res_buf;
              state      <= S_IDLE;
            end else begin
              for (int k = 0; k < RESULT_BYTES; k++)
                if (cnt == CW'(k)) res_buf[8*k +: 8] <= dout;
              cnt <= cnt + 1'b1;
            end
          end else if (tmo) begin
            timeout <= 1'b1;
            state   <= S_IDLE;
          end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_host_link_master.sv
// Bench for host_link_master: plays the far end and the Transmitter,
// predicting the byte stream and job/result outcomes from protocol rules.
module tb_host_link_master;
  localparam int NT = 5;
  localparam int PB = 4;
  localparam int RB = 4 + NT;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          res = 1'b1;
  logic          drl;
  logic [7:0]    din;
  logic          load = 1'b0;
  logic          take = 1'b0;
  logic [7:0]    dout = 8'h00;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [PB*8-1:0] job_data = '0;
  logic          job_done;
  logic          job_ok;
  logic          rslt_valid;
  logic          rslt_fail;
  logic          rslt_err;
  logic [RB*8-1:0] rslt_data;
  logic          timeout;

  host_link_master #(
    .NUM_OF_TAPS(NT),
    .PAYLOAD_BYTES(PB),
    .RESULT_BYTES(RB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .res(res), .drl(drl), .din(din), .load(load),
    .take(take), .dout(dout), .job_valid(job_valid),
    .job_ready(job_ready), .job_data(job_data), .job_done(job_done),
    .job_ok(job_ok), .rslt_valid(rslt_valid), .rslt_fail(rslt_fail),
    .rslt_err(rslt_err), .rslt_data(rslt_data), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors = 0;
  int done_cnt = 0;
  int rv_cnt = 0;
  int to_cnt = 0;
  logic last_ok = 1'b0;
  logic last_fail = 1'b0;
  logic last_err = 1'b0;
  logic [RB*8-1:0] last_data = '0;
  logic p_drl = 1'b0;
  logic [7:0] p_din = 8'h00;
  logic [7:0] txq[$];

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock; models the Transmitter consuming din after a random delay
  task automatic tick();
    logic ld_now;
    ld_now = load;
    @(posedge clk);
    #1;
    if (ld_now) load = 1'b0;
    if (job_done) begin
      done_cnt++;
      last_ok = job_ok;
    end
    if (rslt_valid) begin
      rv_cnt++;
      last_fail = rslt_fail;
      last_err  = rslt_err;
      last_data = rslt_data;
    end
    if (timeout) to_cnt++;
    if (p_drl && !ld_now && drl)
      chk("din_hold", 128'(din), 128'(p_din));
    p_drl = drl;
    p_din = din;
    if (!ld_now && drl && !res && $urandom_range(0, 2) == 0) begin
      load = 1'b1;
      txq.push_back(din);
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    dout = b;
    take = 1'b1;
    tick();
    take = 1'b0;
  endtask

  task automatic expect_tx(input string tag, input logic [39:0] bytes,
                           input int n);
    int w;
    logic [8:0] obs;
    w = 0;
    while (txq.size() < n && w < 400) begin
      tick();
      w++;
    end
    for (int i = 0; i < n; i++) begin
      obs = (txq.size() > 0) ? {1'b0, txq.pop_front()} : 9'h1FF;
      chk(tag, 128'(obs), 128'({1'b0, bytes[8*i +: 8]}));
    end
    tick();
  endtask

  task automatic submit(input logic [31:0] s);
    chk("ready_pre", 128'(job_ready), 128'(1));
    job_data  = s;
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
  endtask

  task automatic run_payload(input logic [31:0] seed,
                             input logic [7:0] reply, input logic junk);
    int d0;
    d0 = done_cnt;
    send_rx(8'hF4);
    expect_tx("payload", {8'hFF, seed}, 5);
    if (junk) send_rx(8'($urandom_range(0, 224)));
    send_rx(reply);
    chk("job_done", 128'(done_cnt), 128'(d0 + 1));
    chk("job_ok", 128'(last_ok), 128'(reply == 8'hF1));
    chk("ready_after", 128'(job_ready), 128'(1));
    chk("tx_quiet", 128'(txq.size()), 128'(0));
  endtask

  task automatic run_result(input logic fail, input logic [7:0] endb,
                            input logic seq);
    logic [RB*8-1:0] exp_d;
    logic [7:0] b;
    int r0;
    r0 = rv_cnt;
    send_rx(fail ? 8'hFA : 8'hF3);
    expect_tx("rack", 40'hF1, 1);
    for (int k = 0; k < RB; k++) begin
      b = seq ? 8'(k + 1) : 8'($urandom);
      exp_d[8*k +: 8] = b;
      send_rx(b);
    end
    send_rx(endb);
    chk("rslt_valid", 128'(rv_cnt), 128'(r0 + 1));
    chk("rslt_fail", 128'(last_fail), 128'(fail));
    chk("rslt_err", 128'(last_err), 128'(endb != 8'hFF));
    chk("rslt_data", 128'(last_data), 128'(exp_d));
  endtask

  initial begin
    int d0;
    int t0;
    int n;
    logic [31:0] seed;
    logic has_ff;
    logic [7:0] reply;

    repeat (3) tick();
    chk("rst_drl", 128'(drl), 128'(0));
    chk("rst_din", 128'(din), 128'(0));
    chk("rst_ready", 128'(job_ready), 128'(0));
    chk("rst_done", 128'(job_done), 128'(0));
    chk("rst_ok", 128'(job_ok), 128'(0));
    chk("rst_rv", 128'(rslt_valid), 128'(0));
    chk("rst_rfail", 128'(rslt_fail), 128'(0));
    chk("rst_rerr", 128'(rslt_err), 128'(0));
    chk("rst_rdata", 128'(rslt_data), 128'(0));
    chk("rst_tmo", 128'(timeout), 128'(0));
    res = 1'b0;
    tick();

    submit(32'h44332211);
    chk("ready_busy", 128'(job_ready), 128'(0));
    expect_tx("start", 40'hF0, 1);
    run_payload(32'h44332211, 8'hF1, 1'b0);

    submit(32'h44332211);
    expect_tx("start", 40'hF0, 1);
    run_payload(32'h44332211, 8'hEE, 1'b0);

    submit(32'hA1B2C3D4);
    expect_tx("start", 40'hF0, 1);
    run_result(1'b0, 8'hFF, 1'b1);
    chk("rdata_b0", 128'(last_data[7:0]), 128'(8'h01));
    expect_tx("restart", 40'hF0, 1);
    run_payload(32'hA1B2C3D4, 8'hF1, 1'b1);

    run_result(1'b1, 8'h00, 1'b0);

    submit(32'h0BADCAFE);
    expect_tx("start", 40'hF0, 1);
    t0 = to_cnt;
    d0 = done_cnt;
    n = 0;
    while (to_cnt == t0 && n < 300) begin
      tick();
      n++;
    end
    chk("timeout_seen", 128'(to_cnt), 128'(t0 + 1));
    chk("timeout_win", 128'(n >= 100 && n <= 102), 128'(1));
    chk("timeout_nodone", 128'(done_cnt), 128'(d0));
    expect_tx("retry", 40'hF0, 1);
    run_payload(32'h0BADCAFE, 8'hF1, 1'b0);

    d0 = done_cnt;
    submit(32'h00FF0000);
    chk("rej_done", 128'(done_cnt), 128'(d0 + 1));
    chk("rej_ok", 128'(last_ok), 128'(0));
    repeat (20) tick();
    chk("rej_notx", 128'(txq.size()), 128'(0));

    for (int j = 0; j < 14; j++) begin
      seed = $urandom;
      if ($urandom_range(0, 3) == 0)
        seed[8*$urandom_range(0, PB-1) +: 8] = 8'hFF;
      has_ff = 1'b0;
      for (int k = 0; k < PB; k++)
        if (seed[8*k +: 8] == 8'hFF) has_ff = 1'b1;
      if ($urandom_range(0, 4) == 0)
        run_result(1'($urandom), $urandom_range(0, 1) ? 8'hFF : 8'h3C, 1'b0);
      d0 = done_cnt;
      submit(seed);
      if (has_ff) begin
        chk("rnd_rej_done", 128'(done_cnt), 128'(d0 + 1));
        chk("rnd_rej_ok", 128'(last_ok), 128'(0));
        repeat (8) tick();
        chk("rnd_rej_notx", 128'(txq.size()), 128'(0));
      end else begin
        expect_tx("rnd_start", 40'hF0, 1);
        if ($urandom_range(0, 2) == 0) begin
          run_result(1'($urandom), $urandom_range(0, 1) ? 8'hFF : 8'h5A,
                     1'b0);
          expect_tx("rnd_restart", 40'hF0, 1);
        end
        reply = $urandom_range(0, 1) ? 8'hF1 : 8'hEE;
        run_payload(seed, reply, 1'($urandom));
      end
    end

    submit(32'h87654321);
    expect_tx("start", 40'hF0, 1);
    send_rx(8'hF4);
    n = 0;
    while (txq.size() < 2 && n < 60) begin
      tick();
      n++;
    end
    chk("pay_started", 128'(txq.size() >= 2), 128'(1));
    d0 = done_cnt;
    res = 1'b1;
    tick();
    chk("midrst_drl", 128'(drl), 128'(0));
    res = 1'b0;
    tick();
    chk("midrst_ready", 128'(job_ready), 128'(1));
    repeat (10) tick();
    chk("midrst_nodone", 128'(done_cnt), 128'(d0));
    chk("midrst_idle", 128'(drl), 128'(0));
    txq.delete();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
